mem_wb_multi: RTL and testbench
===============================

Name: mem_wb_multi

Overview:
- Parametrised MEM→WB pipeline register; successor of the single-lane MEM/WB latch.
- Carries LANES independent write-back channels from the memory stage to the register file.
- Adds: parameter-selected stall-bit index, explicit flush, x0 write suppression, saturating retired-write counter.
- Sits between mem stage and register file; consumes the ctrl stall vector.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- LANES, 2, number of write-back channels (≥1); lane 0 occupies the lowest bit slice of every packed bus
- STALL_W, 6, width of stall vector from ctrl
- STAGE_IDX, 4, stall bit owned by this stage; STAGE_IDX+1 is the downstream bit (STAGE_IDX+1 < STALL_W)
- ZERO_GUARD, 1, 1 = suppress enables whose address is 0
- CNT_W, 32, retired-write counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets on clk rising edge)
- stall  in  STALL_W  pipeline stall vector from ctrl
- flush  in  1  squash this stage's next content
- mem_rd_data  in  LANES*DATA_W  per-lane write data
- mem_rd_addr  in  LANES*ADDR_W  per-lane destination register
- mem_rd_enable  in  LANES  per-lane write enable
- wb_rd_data  out  LANES*DATA_W  registered write data to register file
- wb_rd_addr  out  LANES*ADDR_W  registered destination
- wb_rd_enable  out  LANES  registered write enable
- wb_any  out  1  registered OR of wb_rd_enable
- retire_cnt  out  CNT_W  count of enabled lane writes captured

Behaviour:
- Let s = stall[STAGE_IDX], d = stall[STAGE_IDX+1].
- Per-edge priority, highest first:
  1. rst==0 → all outputs 0, retire_cnt=0.
  2. flush==1 → bubble.
  3. s && !d → bubble.
  4. !s → advance.
  5. s && d → hold all outputs unchanged.
- Bubble: every lane data=0, addr=0, enable=0; wb_any=0; retire_cnt unchanged.
- Advance: each lane independently latches data/addr/enable from mem_*.
  - If ZERO_GUARD=1 and the lane's addr==0, that lane's latched enable is 0; data and addr are still latched as presented.
- wb_any is registered from the same next-state enables as wb_rd_enable, never derived combinationally from outputs.
- retire_cnt: on advance only, add the popcount of the post-guard next enables (0..LANES).
  - Saturates at 2^CNT_W−1: no wrap; a partial add that would exceed the max clamps to the max.
  - Holds on bubble, hold and flush.
- Latency: one cycle from mem_* to wb_*. No combinational path from any input to any output.
- Flush together with s && d → bubble; flush overrides hold.
- Reset mid-stall: reset wins; on the first edge after rst returns high, normal priority applies.
- Lanes are fully independent. No intra-bundle ordering or same-address arbitration here; the register file resolves same-address writes (highest lane wins there).
- LANES=1, STAGE_IDX=4, ZERO_GUARD=0 reproduces the legacy single-lane MEM/WB behaviour exactly (retire_cnt extra).

Test Plan:
- Reset: rst=0 for 2 edges with nonzero inputs → all wb_* = 0, wb_any=0, retire_cnt=0.
- Advance: stall=0, lane0 {0xDEADBEEF, x3, en=1}, lane1 {0x12345678, x7, en=1} → next edge: outputs match, wb_any=1, retire_cnt=2.
- Bubble vs hold: with outputs loaded, stall=6'b010000 → outputs 0, retire_cnt unchanged. Reload, then stall=6'b110000 for 3 edges → outputs and counter frozen at loaded values.
- Zero guard: lane0 addr=0 en=1 data=0x55, lane1 addr=x1 en=1 → wb_rd_enable=2'b10, lane0 addr=0 and data=0x55 latched, retire_cnt+=1.
- Flush priority: stall=6'b110000 with flush=1 → bubble. Then flush=0 with stall=0 → advance resumes in the same edge.
- Saturation: CNT_W=4, preload to 14 via 7 dual-lane advances, then one more dual-lane advance → retire_cnt=15. Further advances keep 15.

Source files
------------

// File: rtl/mem_wb_multi.sv
// MEM->WB pipeline register carrying LANES independent write-back channels to the register file.
// Latency: one cycle from mem_* to wb_*; every output is a flop, with no combinational input-to-output path.
// Backpressure: stall[STAGE_IDX] holds or bubbles this stage depending on stall[STAGE_IDX+1]; flush forces a bubble.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            synchronous reset, active low
//   stall          stall vector from ctrl; this stage owns bit STAGE_IDX, downstream is STAGE_IDX+1
//   flush          squash the content entering this stage on the next edge
//   mem_rd_*       per-lane write data / destination / enable from the memory stage (lane 0 = low slice)
//   wb_rd_*        registered per-lane write data / destination / enable to the register file
//   wb_any         registered OR of the next-state enables
//   retire_cnt     saturating count of enabled lane writes captured on advance
module mem_wb_multi #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LANES      = 2,
    parameter int STALL_W    = 6,
    parameter int STAGE_IDX  = 4,
    parameter int ZERO_GUARD = 1,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic [LANES*DATA_W-1:0]   mem_rd_data,
    input  logic [LANES*ADDR_W-1:0]   mem_rd_addr,
    input  logic [LANES-1:0]          mem_rd_enable,
    output logic [LANES*DATA_W-1:0]   wb_rd_data,
    output logic [LANES*ADDR_W-1:0]   wb_rd_addr,
    output logic [LANES-1:0]          wb_rd_enable,
    output logic                      wb_any,
    output logic [CNT_W-1:0]          retire_cnt
);

    // Popcount of LANES enables needs to represent 0..LANES.
    localparam int PC_W  = $clog2(LANES + 1);
    // Sum is computed one bit wider than either operand so overflow is visible.
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_ADVANCE = 2'd2
    } action_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LANES*DATA_W-1:0] data_q, data_d;
    logic [LANES*ADDR_W-1:0] addr_q, addr_d;
    logic [LANES-1:0]        en_q,   en_d;
    logic                    any_q,  any_d;
    logic [CNT_W-1:0]        cnt_q,  cnt_d;

    // ------------------------------------------------------------------
    // Stall decode
    // ------------------------------------------------------------------
    logic    stall_own;
    logic    stall_down;
    action_e act;

    assign stall_own  = stall[STAGE_IDX];
    assign stall_down = stall[STAGE_IDX+1];

    // Only two bits of the ctrl vector matter to this stage.
    logic unused_stall;
    assign unused_stall = ^stall;

    always_comb begin
        act = ACT_HOLD;
        if (flush) begin
            act = ACT_BUBBLE;
        end else if (stall_own && !stall_down) begin
            // Downstream keeps moving while we are stuck: emit a bubble so the
            // register file never sees the same write twice.
            act = ACT_BUBBLE;
        end else if (!stall_own) begin
            act = ACT_ADVANCE;
        end else begin
            act = ACT_HOLD;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane x0 write suppression. Data and address still pass through
    // untouched; only the enable is killed.
    // ------------------------------------------------------------------
    logic [LANES-1:0] guarded_en;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic addr_is_zero;
        assign addr_is_zero = (mem_rd_addr[g*ADDR_W +: ADDR_W] == '0);
        if (ZERO_GUARD != 0) begin : g_guard
            assign guarded_en[g] = mem_rd_enable[g] & ~addr_is_zero;
        end else begin : g_noguard
            logic unused_zero;
            assign unused_zero   = addr_is_zero;
            assign guarded_en[g] = mem_rd_enable[g];
        end
    end

    // ------------------------------------------------------------------
    // Saturating retire counter increment
    // ------------------------------------------------------------------
    logic [PC_W-1:0]  pop_cnt;
    logic [SUM_W-1:0] cnt_sum;
    logic [SUM_W-1:0] cnt_max_ext;
    logic [CNT_W-1:0] cnt_sat;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            pop_cnt = pop_cnt + PC_W'(guarded_en[i]);
        end
    end

    always_comb begin
        cnt_sum     = SUM_W'(cnt_q) + SUM_W'(pop_cnt);
        cnt_max_ext = SUM_W'({CNT_W{1'b1}});
        // A partial add that would overshoot clamps to the maximum rather than wrapping.
        if (cnt_sum > cnt_max_ext) begin
            cnt_sat = {CNT_W{1'b1}};
        end else begin
            cnt_sat = cnt_sum[CNT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        addr_d = addr_q;
        en_d   = en_q;
        any_d  = any_q;
        cnt_d  = cnt_q;
        unique case (act)
            ACT_BUBBLE: begin
                data_d = '0;
                addr_d = '0;
                en_d   = '0;
                any_d  = 1'b0;
            end
            ACT_ADVANCE: begin
                data_d = mem_rd_data;
                addr_d = mem_rd_addr;
                en_d   = guarded_en;
                // Taken from the next-state enables so wb_any is a true flop output.
                any_d  = |guarded_en;
                cnt_d  = cnt_sat;
            end
            default: begin
                // Hold: everything keeps its value.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            addr_q <= '0;
            en_q   <= '0;
            any_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            addr_q <= addr_d;
            en_q   <= en_d;
            any_q  <= any_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wb_rd_data   = data_q;
    assign wb_rd_addr   = addr_q;
    assign wb_rd_enable = en_q;
    assign wb_any       = any_q;
    assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_mem_wb_multi.sv
// Bench for mem_wb_multi: two instances share stimulus, one with a 32-bit
// counter and one with a 4-bit counter so saturation is reachable.
module tb_mem_wb_multi;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LN = 2;
    localparam int SW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [SW-1:0]      stall;
    logic               flush;
    logic [LN*DW-1:0]   mem_rd_data;
    logic [LN*AW-1:0]   mem_rd_addr;
    logic [LN-1:0]      mem_rd_enable;

    logic [LN*DW-1:0]   wb_rd_data,   s_wb_rd_data;
    logic [LN*AW-1:0]   wb_rd_addr,   s_wb_rd_addr;
    logic [LN-1:0]      wb_rd_enable, s_wb_rd_enable;
    logic               wb_any,       s_wb_any;
    logic [31:0]        retire_cnt;
    logic [3:0]         s_retire_cnt;

    mem_wb_multi #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN), .STALL_W(SW),
                   .STAGE_IDX(4), .ZERO_GUARD(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
        .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_rd_enable(wb_rd_enable),
        .wb_any(wb_any), .retire_cnt(retire_cnt)
    );

    mem_wb_multi #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN), .STALL_W(SW),
                   .STAGE_IDX(4), .ZERO_GUARD(1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
        .wb_rd_data(s_wb_rd_data), .wb_rd_addr(s_wb_rd_addr), .wb_rd_enable(s_wb_rd_enable),
        .wb_any(s_wb_any), .retire_cnt(s_retire_cnt)
    );

    // Expected visible state after one clock edge.
    typedef struct {
        logic [LN*DW-1:0] data;
        logic [LN*AW-1:0] addr;
        logic [LN-1:0]    en;
        logic             any;
        longint unsigned  cnt;
        int unsigned      cnt4;
        string            tag;
    } exp_t;

    exp_t sb[$];
    exp_t m;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit stim_done = 1'b0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        total_cnt++;
        if (act == req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic chk_wide(input string name, input logic [LN*DW-1:0] act, input logic [LN*DW-1:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: applies the edge rules directly to the expected register contents.
    task automatic model_edge(input logic r, input logic f, input logic [SW-1:0] st,
                              input logic [LN*DW-1:0] dat, input logic [LN*AW-1:0] ad,
                              input logic [LN-1:0] en);
        bit s, d;
        int n;
        s = st[4];
        d = st[5];
        if (!r) begin
            m.data = '0; m.addr = '0; m.en = '0; m.any = 1'b0; m.cnt = 0; m.cnt4 = 0;
        end else if (f || (s && !d)) begin
            m.data = '0; m.addr = '0; m.en = '0; m.any = 1'b0;
        end else if (!s) begin
            n = 0;
            m.data = dat;
            m.addr = ad;
            for (int i = 0; i < LN; i++) begin
                m.en[i] = en[i] && (ad[i*AW +: AW] != 0);
                if (m.en[i]) n++;
            end
            m.any  = (n != 0);
            m.cnt  = (m.cnt + n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m.cnt + n;
            m.cnt4 = (m.cnt4 + n > 15) ? 15 : m.cnt4 + n;
        end
        // s && d without flush: nothing changes.
    endtask

    task automatic step(input string tag, input logic r, input logic f, input logic [SW-1:0] st,
                        input logic [LN*DW-1:0] dat, input logic [LN*AW-1:0] ad,
                        input logic [LN-1:0] en);
        exp_t e;
        @(negedge clk);
        rst           = r;
        flush         = f;
        stall         = st;
        mem_rd_data   = dat;
        mem_rd_addr   = ad;
        mem_rd_enable = en;
        model_edge(r, f, st, dat, ad, en);
        e     = m;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: every edge with an outstanding expectation is checked 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_wide({e.tag, ".data"}, wb_rd_data, e.data);
                chk({e.tag, ".addr"},   longint'(wb_rd_addr),   longint'(e.addr));
                chk({e.tag, ".en"},     longint'(wb_rd_enable), longint'(e.en));
                chk({e.tag, ".any"},    longint'(wb_any),       longint'(e.any));
                chk({e.tag, ".cnt"},    longint'(retire_cnt),   e.cnt);
                chk({e.tag, ".cnt4"},   longint'(s_retire_cnt), longint'(e.cnt4));
                chk({e.tag, ".s_en"},   longint'(s_wb_rd_enable), longint'(e.en));
                chk_wide({e.tag, ".s_data"}, s_wb_rd_data, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

    localparam logic [SW-1:0] ST_RUN    = 6'b000000;
    localparam logic [SW-1:0] ST_BUBBLE = 6'b010000;
    localparam logic [SW-1:0] ST_HOLD   = 6'b110000;

    initial begin
        logic [LN*DW-1:0] rd;
        logic [LN*AW-1:0] ra;
        logic [LN-1:0]    re;
        logic [SW-1:0]    rs;
        logic             rr, rf;

        m.data = '0; m.addr = '0; m.en = '0; m.any = 1'b0; m.cnt = 0; m.cnt4 = 0; m.tag = "";
        rst = 1'b0; flush = 1'b0; stall = '0;
        mem_rd_data = '0; mem_rd_addr = '0; mem_rd_enable = '0;

        // Reset held for two edges with busy inputs.
        step("reset0", 0, 0, ST_RUN, {32'hCAFEF00D, 32'h0BADBEEF}, {5'd9, 5'd4}, 2'b11);
        step("reset1", 0, 1, ST_HOLD, {32'h11111111, 32'h22222222}, {5'd2, 5'd5}, 2'b11);

        // Plain dual-lane advance.
        step("advance", 1, 0, ST_RUN, {32'h12345678, 32'hDEADBEEF}, {5'd7, 5'd3}, 2'b11);

        // Own stall with downstream free: bubble, counter unchanged.
        step("bubble", 1, 0, ST_BUBBLE, {32'hAAAA5555, 32'h5555AAAA}, {5'd8, 5'd9}, 2'b11);

        // Reload, then freeze for three edges while inputs keep changing.
        step("reload", 1, 0, ST_RUN, {32'h0F0F0F0F, 32'hF0F0F0F0}, {5'd30, 5'd31}, 2'b01);
        step("hold0", 1, 0, ST_HOLD, {32'h1, 32'h2}, {5'd1, 5'd2}, 2'b11);
        step("hold1", 1, 0, ST_HOLD | 6'b001111, {32'h3, 32'h4}, {5'd3, 5'd4}, 2'b11);
        step("hold2", 1, 0, ST_HOLD, {32'h5, 32'h6}, {5'd5, 5'd6}, 2'b11);

        // x0 write suppression on lane 0 only.
        step("zguard", 1, 0, ST_RUN, {32'h000000AA, 32'h00000055}, {5'd1, 5'd0}, 2'b11);

        // Flush beats hold, then advance resumes immediately.
        step("flush_hold", 1, 1, ST_HOLD, {32'h77777777, 32'h88888888}, {5'd11, 5'd12}, 2'b11);
        step("post_flush", 1, 0, ST_RUN, {32'h99999999, 32'hABCDEF01}, {5'd13, 5'd14}, 2'b10);

        // Reset arriving during a stall wins, then normal priority returns.
        step("rst_in_hold", 0, 0, ST_HOLD, {32'h1, 32'h1}, {5'd1, 5'd1}, 2'b11);
        step("after_rst", 1, 0, ST_HOLD, {32'h2, 32'h2}, {5'd2, 5'd2}, 2'b11);

        // Saturation on the 4-bit counter: 7 dual advances -> 14, then clamp at 15.
        step("sat_rst", 0, 0, ST_RUN, '0, '0, '0);
        for (int i = 0; i < 7; i++) begin
            step("sat_fill", 1, 0, ST_RUN, {32'(i), 32'(i + 100)}, {5'd3, 5'd4}, 2'b11);
        end
        step("sat_clamp", 1, 0, ST_RUN, {32'hF00D, 32'hBEEF}, {5'd5, 5'd6}, 2'b11);
        step("sat_keep0", 1, 0, ST_RUN, {32'h1, 32'h2}, {5'd7, 5'd8}, 2'b11);
        step("sat_keep1", 1, 0, ST_RUN, {32'h3, 32'h4}, {5'd9, 5'd10}, 2'b01);

        // Randomised traffic.
        step("rnd_rst", 0, 0, ST_RUN, '0, '0, '0);
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 39) != 0);
            rf = ($urandom_range(0, 7) == 0);
            rs = 6'($urandom);
            if ($urandom_range(0, 1) == 0) rs[4] = 1'b0;
            rd = {$urandom, $urandom};
            ra = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            re = 2'($urandom);
            step("rnd", rr, rf, rs, rd, ra, re);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", longint'(sb.size()), 0);
        stim_done = 1'b1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
